// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer placing two requesters onto one shared combinational ALU.
// Operands are registered, held for EXEC_CYCLES, then the ALU result is returned on a tagged response.
module alu_share_arb #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_mod,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_mod,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_mod,
    input  logic [31:0] alu_c,
    input  logic        alu_z,
    input  logic        alu_o,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_c,
    output logic        rsp_z,
    output logic        rsp_o
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       last_grant;
    logic       id_reg;
    logic       grant;
    logic       any_valid;
    logic       accept;
    logic       done;

    assign any_valid = req0_valid | req1_valid;
    // On a tie the requester that lost last time wins; otherwise the lone valid one.
    assign grant     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign rsp_id    = id_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                // Readies are masked while in reset so no requester sees a phantom handshake.
                req0_ready = rst_n && any_valid && !grant;
                req1_ready = rst_n && any_valid && grant;
                accept     = any_valid;
                if (any_valid) state_nxt = EXEC;
            end
            EXEC: begin
                done = (cnt == 4'd0);
                if (done) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_mod    <= 3'b100;
            cnt        <= '0;
            last_grant <= 1'b1;
            id_reg     <= 1'b0;
            rsp_c      <= '0;
            rsp_z      <= 1'b0;
            rsp_o      <= 1'b0;
        end else if (accept) begin
            alu_a   <= grant ? req1_a   : req0_a;
            alu_b   <= grant ? req1_b   : req0_b;
            alu_mod <= grant ? req1_mod : req0_mod;
            id_reg  <= grant;
            cnt     <= CNT_INIT;
        end else if (state == EXEC) begin
            if (done) begin
                rsp_c      <= alu_c;
                rsp_z      <= alu_z;
                rsp_o      <= alu_o;
                last_grant <= id_reg;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: one instance with EXEC_CYCLES=1 and one with EXEC_CYCLES=4,
// each connected to a behavioural model of the shared ALU.
module tb_alu_share_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Shared ALU model: returns {overflow(bit 32 of extended result), zero, result}
    function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m);
        logic [32:0] e;
        case (m)
            3'b100:  e = {1'b0, a} + {1'b0, b};
            3'b110:  e = {1'b0, a} - {1'b0, b};
            3'b000:  e = {1'b0, a & b};
            3'b001:  e = {1'b0, a | b};
            3'b011:  e = ($signed(a) < $signed(b)) ? 33'd1 : 33'd0;
            3'b010:  e = {1'b0, a ^ b};
            3'b111:  e = {1'b0, ~(a | b)};
            default: e = '0;
        endcase
        return {e[32], (e[31:0] == 32'd0), e[31:0]};
    endfunction

    // ---------------- instance with EXEC_CYCLES = 1 ----------------
    logic        rst_n1 = 1'b0;
    logic        v0, r0, v1, r1;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  m0, m1;
    logic [31:0] aa, ab, ac;
    logic [2:0]  am;
    logic        az, ao;
    logic        rv, rr, rid, rz, ro;
    logic [31:0] rc;
    assign {ao, az, ac} = alu_f(aa, ab, am);

    alu_share_arb #(.EXEC_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n1),
        .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0), .req0_mod(m0),
        .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1), .req1_mod(m1),
        .alu_a(aa), .alu_b(ab), .alu_mod(am), .alu_c(ac), .alu_z(az), .alu_o(ao),
        .rsp_valid(rv), .rsp_ready(rr), .rsp_id(rid), .rsp_c(rc), .rsp_z(rz), .rsp_o(ro)
    );

    // ---------------- instance with EXEC_CYCLES = 4 ----------------
    logic        rst_n4 = 1'b0;
    logic        v0_4, r0_4, v1_4, r1_4;
    logic [31:0] a0_4, b0_4, a1_4, b1_4;
    logic [2:0]  m0_4, m1_4;
    logic [31:0] aa_4, ab_4, ac_4;
    logic [2:0]  am_4;
    logic        az_4, ao_4;
    logic        rv_4, rr_4, rid_4, rz_4, ro_4;
    logic [31:0] rc_4;
    assign {ao_4, az_4, ac_4} = alu_f(aa_4, ab_4, am_4);

    alu_share_arb #(.EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n4),
        .req0_valid(v0_4), .req0_ready(r0_4), .req0_a(a0_4), .req0_b(b0_4), .req0_mod(m0_4),
        .req1_valid(v1_4), .req1_ready(r1_4), .req1_a(a1_4), .req1_b(b1_4), .req1_mod(m1_4),
        .alu_a(aa_4), .alu_b(ab_4), .alu_mod(am_4), .alu_c(ac_4), .alu_z(az_4), .alu_o(ao_4),
        .rsp_valid(rv_4), .rsp_ready(rr_4), .rsp_id(rid_4), .rsp_c(rc_4), .rsp_z(rz_4), .rsp_o(ro_4)
    );

    int g_id [4];
    int g_cyc[4];
    int ng;

    initial begin
        v0 = 0; v1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; m0 = 0; m1 = 0; rr = 0;
        v0_4 = 0; v1_4 = 0; a0_4 = 0; b0_4 = 0; a1_4 = 0; b1_4 = 0; m0_4 = 0; m1_4 = 0; rr_4 = 0;

        // ---- reset values ----
        repeat (2) @(negedge clk);
        check_eq("rst_rsp_valid", 32'(rv), 32'd0);
        check_eq("rst_req0_ready", 32'(r0), 32'd0);
        check_eq("rst_alu_mod", 32'(am), 32'd4);
        check_eq("rst_alu_a", aa, 32'd0);
        check_eq("rst_rsp_c", rc, 32'd0);
        check_eq("rst_rsp_id", 32'(rid), 32'd0);
        rst_n1 = 1'b1;
        rst_n4 = 1'b1;

        // ---- single request, sub 5-3 ----
        @(negedge clk);
        v0 = 1; a0 = 32'd5; b0 = 32'd3; m0 = 3'b110; rr = 1;
        #1;
        check_eq("single_req0_ready", 32'(r0), 32'd1);
        check_eq("single_req1_ready", 32'(r1), 32'd0);
        @(negedge clk);
        v0 = 0;
        check_eq("single_ready_drop", 32'(r0), 32'd0);
        check_eq("single_alu_a", aa, 32'd5);
        check_eq("single_alu_b", ab, 32'd3);
        check_eq("single_alu_mod", 32'(am), 32'd6);
        check_eq("single_no_rsp_yet", 32'(rv), 32'd0);
        @(negedge clk);
        check_eq("single_rsp_valid", 32'(rv), 32'd1);
        check_eq("single_rsp_id", 32'(rid), 32'd0);
        check_eq("single_rsp_c", rc, 32'd2);
        check_eq("single_rsp_z", 32'(rz), 32'd0);
        @(negedge clk);
        check_eq("single_rsp_consumed", 32'(rv), 32'd0);

        // ---- tie fairness after fresh reset ----
        rst_n1 = 0;
        v0 = 1; a0 = 32'h0000_00F0; b0 = 32'h0000_000F; m0 = 3'b001;
        v1 = 1; a1 = 32'hFFFF_FFFF; b1 = 32'd1;        m1 = 3'b011;
        #1;
        check_eq("rst_ready_masked", 32'(r0 | r1), 32'd0);
        @(negedge clk);
        rst_n1 = 1;
        ng = 0;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            #1;
            if (r0 || r1) begin
                g_id[ng]  = r1 ? 1 : 0;
                g_cyc[ng] = i;
                ng++;
            end
            if (rv) check_eq("fair_rsp_c", rc, rid ? 32'd1 : 32'h0000_00FF);
            @(negedge clk);
        end
        check_eq("fair_grant_count", 32'(ng), 32'd4);
        check_eq("fair_g0", 32'(g_id[0]), 32'd0);
        check_eq("fair_g1", 32'(g_id[1]), 32'd1);
        check_eq("fair_g2", 32'(g_id[2]), 32'd0);
        check_eq("fair_g3", 32'(g_id[3]), 32'd1);
        check_eq("fair_period0", 32'(g_cyc[2] - g_cyc[0]), 32'd6);
        check_eq("fair_period1", 32'(g_cyc[3] - g_cyc[1]), 32'd6);
        v0 = 0; v1 = 0;
        repeat (4) @(negedge clk);

        // ---- backpressure with req1 xor ----
        rr = 0;
        v1 = 1; a1 = 32'hFFFF_0000; b1 = 32'hFFFF_0000; m1 = 3'b010;
        #1;
        check_eq("bp_req1_ready", 32'(r1), 32'd1);
        @(negedge clk);
        v1 = 0;
        v0 = 1; a0 = 32'd7; b0 = 32'd7; m0 = 3'b100;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_rsp_valid", 32'(rv), 32'd1);
            check_eq("bp_rsp_id", 32'(rid), 32'd1);
            check_eq("bp_rsp_c", rc, 32'd0);
            check_eq("bp_rsp_z", 32'(rz), 32'd1);
            check_eq("bp_no_ready", 32'(r0 | r1), 32'd0);
            @(negedge clk);
        end
        v0 = 0; rr = 1;
        @(negedge clk);
        check_eq("bp_released", 32'(rv), 32'd0);

        // ---- EXEC_CYCLES=4: add 0x7FFFFFFF + 1 ----
        rr_4 = 1;
        v0_4 = 1; a0_4 = 32'h7FFF_FFFF; b0_4 = 32'd1; m0_4 = 3'b100;
        #1;
        check_eq("e4_req0_ready", 32'(r0_4), 32'd1);
        @(negedge clk);
        v0_4 = 0;
        for (int i = 0; i < 4; i++) begin
            check_eq("e4_alu_a", aa_4, 32'h7FFF_FFFF);
            check_eq("e4_alu_b", ab_4, 32'd1);
            check_eq("e4_alu_mod", 32'(am_4), 32'd4);
            check_eq("e4_no_rsp", 32'(rv_4), 32'd0);
            @(negedge clk);
        end
        check_eq("e4_rsp_valid", 32'(rv_4), 32'd1);
        check_eq("e4_rsp_c", rc_4, 32'h8000_0000);
        check_eq("e4_rsp_o", 32'(ro_4), 32'd0);
        check_eq("e4_rsp_z", 32'(rz_4), 32'd0);
        @(negedge clk);

        // ---- reset during EXEC ----
        v0_4 = 1; a0_4 = 32'd1; b0_4 = 32'd2; m0_4 = 3'b110;
        #1;
        check_eq("mid_accept", 32'(r0_4), 32'd1);
        @(negedge clk);
        v0_4 = 0;
        check_eq("mid_in_exec_mod", 32'(am_4), 32'd6);
        #2 rst_n4 = 0;
        #1;
        check_eq("mid_alu_mod", 32'(am_4), 32'd4);
        check_eq("mid_alu_a", aa_4, 32'd0);
        v0_4 = 1; v1_4 = 1; a1_4 = 32'd9; b1_4 = 32'd9; m1_4 = 3'b000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("mid_no_rsp", 32'(rv_4), 32'd0);
        end
        check_eq("mid_ready_masked", 32'(r0_4 | r1_4), 32'd0);
        rst_n4 = 1;
        #1;
        check_eq("mid_post_req0", 32'(r0_4), 32'd1);
        check_eq("mid_post_req1", 32'(r1_4), 32'd0);
        @(negedge clk);
        v0_4 = 0; v1_4 = 0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter and sequencer for the shared 32-bit ALU. It accepts operation requests (operands plus 3-bit ALU mode) from two requesters, such as the execute stage and an address/branch unit. It grants one request at a time by round-robin and drives the registered operands into the ALU for a fixed settle window. It then captures result, zero and overflow, and returns them on a single tagged response channel. It sits between the requesters and the single combinational ALU instance, so the ALU is never driven by two sources at once.

## Interface
- EXEC_CYCLES, 1, ALU settle cycles per operation; legal range 1..15.
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  32 each  operands from requester 0
- req0_mod  in  3  ALU mode from requester 0 (100 add/addu, 110 sub, 000 and, 001 or, 011 slt, 010 xor, 111 nor)
- req1_valid, req1_ready, req1_a, req1_b, req1_mod  as above, requester 1
- alu_a, alu_b  out  32 each  to shared ALU operands
- alu_mod  out  3  to shared ALU mode
- alu_c  in  32  ALU result
- alu_z  in  1  ALU zero flag
- alu_o  in  1  ALU overflow (bit 32 of extended result)
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester the response belongs to
- rsp_c  out  32  captured result
- rsp_z, rsp_o  out  1 each  captured flags

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE
  - Grant is computed combinationally from the valids and last_grant, using round-robin.
  - The requester that did not win last time wins a tie.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - reqN_ready = (state==IDLE) && grant==N. At most one ready is high.
  - A request is accepted when valid&&ready. On acceptance:
    - a/b/mod are latched into operand registers;
    - the grant is latched into id_reg;
    - cnt is loaded with EXEC_CYCLES-1;
    - the FSM moves to EXEC.
  - With no valid, the FSM stays in IDLE and operand registers hold.
- EXEC
  - alu_a/alu_b/alu_mod are driven from the operand registers only; they never come combinationally from the request ports.
  - cnt decrements each cycle. In the cycle cnt==0:
    - alu_c/alu_z/alu_o are captured into result registers;
    - last_grant <= id_reg;
    - the FSM moves to RESP.
- RESP
  - rsp_valid=1 and rsp_id/rsp_c/rsp_z/rsp_o are held stable.
  - On rsp_ready the FSM returns to IDLE. Otherwise it stays.
- Request inputs are ignored outside IDLE.
- Requesters must hold valid and payload stable until ready; the block does not check this.
- The result is passed through bit-exact from the ALU. The block does no arithmetic.
- Reset values:
  - req0_ready, req1_ready, rsp_valid, rsp_id, rsp_z, rsp_o = 0; rsp_c = 0;
  - alu_a = alu_b = 0; alu_mod = 3'b100;
  - cnt = 0; last_grant = 1.

## Timing
- Request accepted at edge T (IDLE, valid&&ready).
- Operands appear on the ALU after T. The EXEC window lasts EXEC_CYCLES cycles.
- Result is captured at edge T+EXEC_CYCLES. rsp_valid is high from then on.
- Latency from acceptance to rsp_valid = EXEC_CYCLES+1 cycles.
- If rsp_ready is already high, the response is consumed at edge T+EXEC_CYCLES+1.
- The next acceptance is possible at edge T+EXEC_CYCLES+2. Peak issue rate is one op per EXEC_CYCLES+2 cycles.
- Backpressure: rsp_ready low holds RESP indefinitely, and both readies stay low.
- rsp_ready high while rsp_valid is low has no effect.
- Simultaneous valids: only the granted requester sees ready. The loser keeps valid and wins the next IDLE cycle.
- Reset asserted mid-EXEC or mid-RESP:
  - the in-flight operation is discarded and no response is produced;
  - all outputs take reset values asynchronously.
- After reset deassertion the first grant follows the last_grant=1 rule.

## Test plan
- Single request, EXEC_CYCLES=1: req0 valid with a=5, b=3, mod=110, rsp_ready=1 -> req0_ready for 1 cycle; alu_a=5, alu_b=3, alu_mod=110 next cycle; rsp_valid 2 cycles after acceptance with rsp_id=0, rsp_c=2, rsp_z=0.
- Tie fairness: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1. With EXEC_CYCLES=1, each requester is accepted every 6 cycles.
- Backpressure: rsp_ready low for 10 cycles after a req1 xor of 0xFFFF0000 and 0xFFFF0000 -> rsp_valid, rsp_id=1, rsp_c=0, rsp_z=1 held stable all 10 cycles; no readies.
- EXEC_CYCLES=4: req0 add of 0x7FFFFFFF and 1 -> ALU inputs stable for 4 cycles; rsp_valid 5 cycles after acceptance with rsp_c=0x80000000 and rsp_o equal to the ALU's alu_o output at capture.
- Reset mid-operation: assert rst_n low during EXEC -> rsp_valid never rises; alu_mod=100 and alu_a=0 immediately. After release with both valid, req0 is granted first.
